// File: rtl/accel_dispatch_if.sv
// accel_dispatch_if: decode/accelerator-side signal bundle for the accelerator dispatcher.
interface accel_dispatch_if;
    logic        halt;
    logic        H_int;
    logic        E_int;
    logic        D_int;
    logic [10:0] offset;
    logic [15:0] read_data_1;
    logic [15:0] read_data_2;
    logic        H_acc_done;
    logic        E_acc_done;
    logic        D_acc_done;
    logic        stall;
    logic        H_start;
    logic        E_start;
    logic        D_start;
    logic [15:0] acc_addr;
    logic [15:0] acc_len;
    logic        H_done;
    logic        E_done;
    logic        D_done;
    logic        timeout_err;
    logic        multi_err;
    modport master (
        output halt, H_int, E_int, D_int, offset, read_data_1, read_data_2,
        output H_acc_done, E_acc_done, D_acc_done,
        input  stall, H_start, E_start, D_start, acc_addr, acc_len,
        input  H_done, E_done, D_done, timeout_err, multi_err
    );
    modport slave (
        input  halt, H_int, E_int, D_int, offset, read_data_1, read_data_2,
        input  H_acc_done, E_acc_done, D_acc_done,
        output stall, H_start, E_start, D_start, acc_addr, acc_len,
        output H_done, E_done, D_done, timeout_err, multi_err
    );
endinterface

// File: rtl/accel_dispatch.sv
// accel_dispatch: launches one hash/encrypt/decrypt job at a time, stalls decode while it runs,
// and pulses the matching done back to decode; a watchdog forces completion on accelerator hangs.
module accel_dispatch #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic             clk,
    input logic             rst_n,
    accel_dispatch_if.slave bus
);
    localparam int              CW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit              WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0]   TO_M1 = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_kind;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_addr;
    logic [15:0]   r_len;
    logic          r_to_err;
    logic          r_multi_err;
    logic          w_req;
    logic          w_multi;
    logic [2:0]    w_kind;
    logic          w_acc_done;
    logic          w_to;

    // Kind is one-hot {D,E,H}; priority H > E > D.
    assign w_req      = (bus.H_int | bus.E_int | bus.D_int) & ~bus.halt;
    assign w_multi    = (bus.H_int & bus.E_int) | (bus.H_int & bus.D_int) | (bus.E_int & bus.D_int);
    assign w_kind     = bus.H_int ? 3'b001 : bus.E_int ? 3'b010 : 3'b100;
    assign w_acc_done = |(r_kind & {bus.D_acc_done, bus.E_acc_done, bus.H_acc_done});
    assign w_to       = WD_EN && (r_cnt == TO_M1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_req ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = (w_acc_done | w_to) ? DONE : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_kind      <= 3'b0;
            r_cnt       <= '0;
            r_addr      <= 16'h0;
            r_len       <= 16'h0;
            r_to_err    <= 1'b0;
            r_multi_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_kind      <= w_kind;
                r_multi_err <= r_multi_err | w_multi;
                r_addr      <= bus.read_data_1 + {5'b0, bus.offset};
                r_len       <= bus.read_data_2;
            end
            if (r_state == ISSUE)
                r_cnt <= '0;
            if (r_state == WAIT)
                r_cnt <= r_cnt + CW'(1);
            // A real done in the same cycle as the watchdog wins and is not an error.
            if (r_state == WAIT && w_to && !w_acc_done)
                r_to_err <= 1'b1;
        end
    end

    assign bus.stall                             = (r_state == IDLE) ? w_req : (r_state != DONE);
    assign {bus.D_start, bus.E_start, bus.H_start} = (r_state == ISSUE) ? r_kind : 3'b0;
    assign {bus.D_done, bus.E_done, bus.H_done}    = (r_state == DONE) ? r_kind : 3'b0;
    assign bus.acc_addr                          = r_addr;
    assign bus.acc_len                           = r_len;
    assign bus.timeout_err                       = r_to_err;
    assign bus.multi_err                         = r_multi_err;
endmodule

// File: tb/tb_accel_dispatch.sv
// tb_accel_dispatch: randomized jobs against a job-level reference model with a start/done scoreboard.
module tb_accel_dispatch;
    localparam int TO = 8;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [15:0] len;
        bit          to;
    } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accel_dispatch_if bus();
    accel_dispatch #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    job_t start_q[$];
    job_t done_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_multi = 0;
    bit   m_to = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] pick(input logic [2:0] req);
        if (req[0]) return 3'b001;
        if (req[1]) return 3'b010;
        if (req[2]) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [40:0] outs();
        return {bus.stall, bus.D_start, bus.E_start, bus.H_start, bus.D_done, bus.E_done, bus.H_done,
                bus.acc_addr, bus.acc_len, bus.timeout_err, bus.multi_err};
    endfunction

    logic [2:0] mon_s, mon_d;
    job_t       mj;
    initial forever begin
        @(posedge clk);
        #1;
        mon_s = {bus.D_start, bus.E_start, bus.H_start};
        mon_d = {bus.D_done, bus.E_done, bus.H_done};
        if (mon_s != 3'b0) begin
            if (start_q.size() == 0) chk("unexpected_start", {61'b0, mon_s}, 64'h0);
            else begin
                mj = start_q.pop_front();
                chk("start_kind", {61'b0, mon_s}, {61'b0, mj.kind});
                chk("acc_addr", {48'b0, bus.acc_addr}, {48'b0, mj.addr});
                chk("acc_len", {48'b0, bus.acc_len}, {48'b0, mj.len});
            end
        end
        if (mon_d != 3'b0) begin
            if (done_q.size() == 0) chk("unexpected_done", {61'b0, mon_d}, 64'h0);
            else begin
                mj = done_q.pop_front();
                if (mj.to) m_to = 1;
                chk("done_kind", {61'b0, mon_d}, {61'b0, mj.kind});
                chk("done_stall", {63'b0, bus.stall}, 64'h0);
                chk("timeout_err", {63'b0, bus.timeout_err}, {63'b0, m_to});
                chk("multi_err", {63'b0, bus.multi_err}, {63'b0, m_multi});
                chk("addr_held", {48'b0, bus.acc_addr}, {48'b0, mj.addr});
                chk("len_held", {48'b0, bus.acc_len}, {48'b0, mj.len});
            end
        end
    end

    // Called and returns at a negedge with the DUT in IDLE; dly==0 means the accelerator never answers.
    task automatic job(input logic [2:0] req, input bit hlt, input logic [15:0] rd1, input logic [10:0] off,
                       input logic [15:0] rd2, input int dly, input logic [2:0] nmask);
        job_t       j;
        logic [2:0] k;
        {bus.D_int, bus.E_int, bus.H_int} = req;
        bus.halt = hlt;
        bus.read_data_1 = rd1;
        bus.offset = off;
        bus.read_data_2 = rd2;
        #1 chk("stall_req", {63'b0, bus.stall}, {63'b0, (req != 3'b0) && !hlt});
        if (hlt || req == 3'b0) begin
            repeat (3) @(negedge clk);
            {bus.D_int, bus.E_int, bus.H_int} = 3'b0;
            bus.halt = 1'b0;
            return;
        end
        k = pick(req);
        j.kind = k;
        j.addr = 16'((int'(rd1) + int'(off)) % 65536);
        j.len = rd2;
        j.to = (dly == 0);
        if ($countones(req) > 1) m_multi = 1;
        start_q.push_back(j);
        done_q.push_back(j);
        @(negedge clk);
        {bus.D_int, bus.E_int, bus.H_int} = 3'b0;
        bus.read_data_1 = 16'($urandom);
        bus.offset = 11'($urandom);
        bus.read_data_2 = 16'($urandom);
        #1 chk("start_latency", {61'b0, bus.D_start, bus.E_start, bus.H_start}, {61'b0, k});
        for (int i = 1; i <= ((dly == 0) ? TO : dly); i++) begin
            @(negedge clk);
            {bus.D_acc_done, bus.E_acc_done, bus.H_acc_done} = (i == dly) ? k : (~k & nmask);
        end
        @(negedge clk);
        {bus.D_acc_done, bus.E_acc_done, bus.H_acc_done} = 3'b0;
        #1 chk("done_latency", {61'b0, bus.D_done, bus.E_done, bus.H_done}, {61'b0, k});
        @(negedge clk);
    endtask

    initial begin
        job_t       r;
        logic [2:0] req;
        bus.halt = 0;
        {bus.D_int, bus.E_int, bus.H_int} = 3'b0;
        {bus.D_acc_done, bus.E_acc_done, bus.H_acc_done} = 3'b0;
        bus.offset = 0;
        bus.read_data_1 = 0;
        bus.read_data_2 = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", {23'b0, outs()}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        job(3'b010, 0, 16'h0100, 11'h010, 16'h0040, 5, 3'b000);
        chk("e_addr", {48'b0, bus.acc_addr}, 64'h0110);
        job(3'b101, 0, 16'h1234, 11'h001, 16'h0008, 3, 3'b000);
        chk("multi_sticky", {63'b0, bus.multi_err}, 64'h1);
        job(3'b100, 0, 16'h2000, 11'h020, 16'h0100, 6, 3'b111);
        job(3'b001, 0, 16'h3000, 11'h000, 16'h0010, TO, 3'b000);
        chk("no_timeout_tie", {63'b0, bus.timeout_err}, 64'h0);
        job(3'b100, 0, 16'h4000, 11'h004, 16'h0020, 0, 3'b000);
        job(3'b001, 0, 16'hFFF8, 11'h7FF, 16'h0003, 2, 3'b000);
        chk("wrap_addr", {48'b0, bus.acc_addr}, 64'h07F7);
        chk("timeout_sticky", {63'b0, bus.timeout_err}, 64'h1);
        job(3'b001, 1, 16'h5555, 11'h055, 16'h0001, 1, 3'b000);

        {bus.D_int, bus.E_int, bus.H_int} = 3'b100;
        bus.read_data_1 = 16'h0A00;
        bus.offset = 11'h00A;
        bus.read_data_2 = 16'h0055;
        r.kind = 3'b100;
        r.addr = 16'h0A0A;
        r.len = 16'h0055;
        r.to = 0;
        start_q.push_back(r);
        @(negedge clk);
        {bus.D_int, bus.E_int, bus.H_int} = 3'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("reset_midjob", {23'b0, outs()}, 64'h0);
        m_to = 0;
        m_multi = 0;
        done_q.delete();
        bus.D_acc_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        bus.D_acc_done = 1'b0;
        #1 chk("stale_done", {23'b0, outs()}, 64'h0);
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            req = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 9) == 0) req = 3'b0;
            job(req, $urandom_range(0, 7) == 0, 16'($urandom), 11'($urandom), 16'($urandom),
                $urandom_range(0, TO), 3'($urandom));
        end
        repeat (2) @(negedge clk);
        chk("queues_empty", 64'(start_q.size() + done_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
